// File: rtl/reg_file_wr_arbiter_if.sv
// Register-file write-port bundle: two requester write channels plus the single arbitrated write port.
interface reg_file_wr_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [ADDR_WIDTH-1:0] req0_reg;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [ADDR_WIDTH-1:0] req1_reg;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_reg;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  idle;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  wr_en, wr_reg, wr_data, idle
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output wr_en, wr_reg, wr_data, idle
  );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Two-requester register-file write arbiter: per-requester queues, round-robin grant, registered write port.
// Optional: define WR_ARB_X0_FILTER_EN to accept-and-drop writes that target x0.
module reg_file_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_file_wr_arbiter_if.slave    bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_WIDTH + DATA_WIDTH;

  logic                  in_valid [2];
  logic [ADDR_WIDTH-1:0] in_reg   [2];
  logic [DATA_WIDTH-1:0] in_data  [2];

  logic [ENT_W-1:0] mem_q    [2][FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d    [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q [2];
  logic [PTR_W-1:0] wr_ptr_d [2];
  logic [PTR_W-1:0] rd_ptr_q [2];
  logic [PTR_W-1:0] rd_ptr_d [2];
  logic [CNT_W-1:0] cnt_q    [2];
  logic [CNT_W-1:0] cnt_d    [2];

  logic                  last_q, last_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_reg_q, wr_reg_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic             ready_c  [2];
  logic             head_vld [2];
  logic             push     [2];
  logic             pop      [2];
  logic             gnt_vld;
  logic             gnt_id;
  logic [ENT_W-1:0] head_ent;

  assign in_valid[0] = bus.req0_valid;
  assign in_reg[0]   = bus.req0_reg;
  assign in_data[0]  = bus.req0_data;
  assign in_valid[1] = bus.req1_valid;
  assign in_reg[1]   = bus.req1_reg;
  assign in_data[1]  = bus.req1_data;

  // Ready looks only at the registered count, so a same-cycle pop never raises it.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      ready_c[n]  = !rst && (cnt_q[n] < CNT_W'(FIFO_DEPTH));
      head_vld[n] = (cnt_q[n] != '0);
`ifdef WR_ARB_X0_FILTER_EN
      push[n]     = in_valid[n] && ready_c[n] && (in_reg[n] != '0);
`else
      push[n]     = in_valid[n] && ready_c[n];
`endif
    end
  end

  // Round-robin: on a tie the queue not granted last wins.
  always_comb begin
    gnt_vld = head_vld[0] || head_vld[1];
    if (head_vld[0] && head_vld[1]) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = head_vld[1];
    end
    pop[0]   = gnt_vld && !gnt_id;
    pop[1]   = gnt_vld && gnt_id;
    head_ent = mem_q[gnt_id][rd_ptr_q[gnt_id]];
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      mem_d[n]    = mem_q[n];
      wr_ptr_d[n] = wr_ptr_q[n];
      rd_ptr_d[n] = rd_ptr_q[n];
      cnt_d[n]    = cnt_q[n];
      if (push[n]) begin
        mem_d[n][wr_ptr_q[n]] = {in_reg[n], in_data[n]};
        wr_ptr_d[n]           = wr_ptr_q[n] + PTR_W'(1);
      end
      if (pop[n]) begin
        rd_ptr_d[n] = rd_ptr_q[n] + PTR_W'(1);
      end
      case ({push[n], pop[n]})
        2'b10:   cnt_d[n] = cnt_q[n] + CNT_W'(1);
        2'b01:   cnt_d[n] = cnt_q[n] - CNT_W'(1);
        default: cnt_d[n] = cnt_q[n];
      endcase
    end
  end

  // Without a grant the write port drops enable and holds its last index/data.
  always_comb begin
    wr_en_d   = gnt_vld;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    last_d    = last_q;
    if (gnt_vld) begin
      {wr_reg_d, wr_data_d} = head_ent;
      last_d                = gnt_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem_q[n][i] <= '0;
        end
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        cnt_q[n]    <= '0;
      end
      last_q    <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.req0_ready = ready_c[0];
  assign bus.req1_ready = ready_c[1];
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_reg     = wr_reg_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.idle       = (cnt_q[0] == '0) && (cnt_q[1] == '0) && !wr_en_q;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// Bench for reg_file_wr_arbiter: queue-based reference model checked every cycle, plus directed literal scenarios.
module tb_reg_file_wr_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int          DEPTH = 2;
`ifdef WR_ARB_X0_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    int r;
    int c;
  } log_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_wr_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  reg_file_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  ent_t src0[$], src1[$];
  ent_t mq0[$], mq1[$];
  log_t wlog[$];
  bit rand_gate = 1'b0;
  bit last_m = 1'b1;
  bit exp_en = 1'b0;
  logic [AW-1:0] exp_reg = '0;
  logic [DW-1:0] exp_data = '0;
  logic [DW-1:0] model_rf [32];
  logic [DW-1:0] dut_rf [32];
  int issued = 0;
  int acc_nf = 0;
  int cyc = 0;
  int ridx = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester drivers: present the head of each source list, optionally with random gaps.
  always @(negedge clk) begin
    #2;
    bus.req0_valid = (!rand_gate || ($urandom_range(0, 3) != 0)) && (src0.size() != 0);
    bus.req1_valid = (!rand_gate || ($urandom_range(0, 3) != 0)) && (src1.size() != 0);
    if (src0.size() != 0) begin
      bus.req0_reg  = src0[0].r;
      bus.req0_data = src0[0].d;
    end
    if (src1.size() != 0) begin
      bus.req1_reg  = src1[0].r;
      bus.req1_data = src1[0].d;
    end
  end

  // Reference model: two FIFO lists, a tie-break bit, and the write the port must show after this edge.
  int  s0, s1;
  bit  a0, a1, g;
  ent_t e;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq0.delete();
      mq1.delete();
      last_m   = 1'b1;
      exp_en   = 1'b0;
      exp_reg  = '0;
      exp_data = '0;
    end else begin
      if (exp_en && exp_reg != '0) model_rf[exp_reg] = exp_data;
      s0 = mq0.size();
      s1 = mq1.size();
      a0 = bus.req0_valid && (s0 < DEPTH);
      a1 = bus.req1_valid && (s1 < DEPTH);
      if (s0 > 0 || s1 > 0) begin
        g        = (s0 > 0 && s1 > 0) ? !last_m : (s1 > 0);
        e        = g ? mq1.pop_front() : mq0.pop_front();
        exp_en   = 1'b1;
        exp_reg  = e.r;
        exp_data = e.d;
        last_m   = g;
      end else begin
        exp_en = 1'b0;
      end
      if (a0) begin
        e = src0.pop_front();
        if (!(FILTER && e.r == '0)) begin
          mq0.push_back(e);
          acc_nf++;
        end
      end
      if (a1) begin
        e = src1.pop_front();
        if (!(FILTER && e.r == '0)) begin
          mq1.push_back(e);
          acc_nf++;
        end
      end
    end
  end

  // Register file fed by the DUT write port.
  always @(posedge clk) begin
    if (!rst && bus.wr_en && bus.wr_reg != '0) dut_rf[bus.wr_reg] <= bus.wr_data;
  end

  // Per-cycle compare against the model.
  log_t le;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_ready0", bus.req0_ready, 0);
      chk("rst_ready1", bus.req1_ready, 0);
      chk("rst_idle", bus.idle, 1);
      chk("rst_wr_en", bus.wr_en, 0);
    end else begin
      chk("ready0", bus.req0_ready, mq0.size() < DEPTH);
      chk("ready1", bus.req1_ready, mq1.size() < DEPTH);
      chk("wr_en", bus.wr_en, exp_en);
      chk("wr_reg", bus.wr_reg, exp_reg);
      chk("wr_data", bus.wr_data, exp_data);
      chk("idle", bus.idle, (mq0.size() == 0) && (mq1.size() == 0) && !exp_en);
      chk("rd_data", dut_rf[ridx], model_rf[ridx]);
      ridx = (ridx + 1) % 32;
      if (bus.wr_en) begin
        issued++;
        le.r = int'(bus.wr_reg);
        le.c = cyc;
        wlog.push_back(le);
      end
    end
  end

  function automatic ent_t mk(input int r, input logic [DW-1:0] d);
    ent_t t;
    t.r = AW'(r);
    t.d = d;
    return t;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #1;
      if (src0.size() == 0 && src1.size() == 0 && bus.idle) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: drain timeout, idle=%0b after %0d cycles, required idle=1", name, bus.idle, budget);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    #3 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq_c[4];
    int seq_b[6];
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_reg = '0;
    bus.req1_reg = '0;
    bus.req0_data = '0;
    bus.req1_data = '0;
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end
    seq_c = '{1, 3, 2, 4};
    seq_b = '{6, 9, 7, 10, 8, 11};

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_wr_reg", bus.wr_reg, 0);
    chk("reset_wr_data", bus.wr_data, 0);
    chk("reset_idle", bus.idle, 1);

    // Single write: accepted at edge 1, on the port after edge 2, readable after edge 3
    rst = 1'b0;
    src0.push_back(mk(5, 32'hDEADBEEF));
    @(negedge clk);
    chk("single_wr_en_edge1", bus.wr_en, 0);
    chk("single_idle_edge1", bus.idle, 0);
    @(negedge clk);
    chk("single_wr_en", bus.wr_en, 1);
    chk("single_wr_reg", bus.wr_reg, 5);
    chk("single_wr_data", bus.wr_data, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_rd_x5", dut_rf[5], 32'hDEADBEEF);
    wait_idle(20, "single");

    // Contention from reset: expect 1,3,2,4 back to back
    reset_pulse();
    wlog.delete();
    src0.push_back(mk(1, 32'h11)); src0.push_back(mk(2, 32'h22));
    src1.push_back(mk(3, 32'h33)); src1.push_back(mk(4, 32'h44));
    wait_idle(30, "contention");
    chk("cont_count", wlog.size(), 4);
    if (wlog.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("cont_seq%0d", i), wlog[i].r, seq_c[i]);
      chk("cont_no_gap", wlog[3].c - wlog[0].c, 3);
    end

    // Backpressure: req1 queue full on its third offer while req0 contends
    reset_pulse();
    wlog.delete();
    src0.push_back(mk(6, 32'h66)); src0.push_back(mk(7, 32'h77)); src0.push_back(mk(8, 32'h88));
    src1.push_back(mk(9, 32'h99)); src1.push_back(mk(10, 32'hAA)); src1.push_back(mk(11, 32'hBB));
    @(negedge clk);
    chk("bp_ready1_second", bus.req1_ready, 1);
    @(negedge clk);
    #3;
    chk("bp_ready1_third", bus.req1_ready, 0);
    chk("bp_valid1_third", bus.req1_valid, 1);
    chk("bp_reg1_third", bus.req1_reg, 11);
    wait_idle(40, "backpressure");
    chk("bp_count", wlog.size(), 6);
    if (wlog.size() == 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("bp_seq%0d", i), wlog[i].r, seq_b[i]);
    end

    // x0 write
    @(negedge clk);
    wlog.delete();
    src0.push_back(mk(0, 32'hFFFFFFFF));
    wait_idle(20, "x0");
`ifdef WR_ARB_X0_FILTER_EN
    chk("x0_no_write", wlog.size(), 0);
`else
    chk("x0_write_count", wlog.size(), 1);
    if (wlog.size() == 1) chk("x0_wr_reg", wlog[0].r, 0);
`endif

    // Reset mid-stream discards everything queued
    reset_pulse();
    src0.push_back(mk(12, 32'hC0)); src0.push_back(mk(13, 32'hD0));
    src1.push_back(mk(14, 32'hE0)); src1.push_back(mk(15, 32'hF0));
    @(negedge clk);
    @(negedge clk);
    chk("mid_wr_en_pre", bus.wr_en, 1);
    chk("mid_wr_reg_pre", bus.wr_reg, 12);
    #3 rst = 1'b1;
    #1;
    chk("mid_wr_en_rst", bus.wr_en, 0);
    chk("mid_idle_rst", bus.idle, 1);
    chk("mid_ready0_rst", bus.req0_ready, 0);
    wlog.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_no_write_after", wlog.size(), 0);
    chk("mid_idle_after", bus.idle, 1);

    // Random run: 1000 transactions with random gaps and random targets
    @(negedge clk);
    issued = 0;
    acc_nf = 0;
    rand_gate = 1'b1;
    for (int i = 0; i < 500; i++) begin
      src0.push_back(mk($urandom_range(0, 31), $urandom));
      src1.push_back(mk($urandom_range(0, 31), $urandom));
    end
    wait_idle(8000, "random");
    rand_gate = 1'b0;
    repeat (2) @(negedge clk);
    chk("rand_issued_vs_accepted", issued, acc_nf);
    for (int i = 0; i < 32; i++) chk($sformatf("rand_rf_x%0d", i), dut_rf[i], model_rf[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_wr_arbiter.md
REG_FILE_WR_ARBITER -- requirements
Module: reg_file_wr_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, width of write data.
REQ-002 Parameter: ADDR_WIDTH, default 5, width of register index.
REQ-003 Parameter: FIFO_DEPTH, default 2, entries per requester queue; power of two, at least 2.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge.
REQ-005 Port: rst  input  1  reset; asynchronous, active-high.
REQ-006 Port: req0_valid  input  1  requester 0 (ALU writeback) offers a write.
REQ-007 Port: req0_ready  output  1  requester 0 queue can accept.
REQ-008 Port: req0_reg  input  ADDR_WIDTH  requester 0 destination register.
REQ-009 Port: req0_data  input  DATA_WIDTH  requester 0 write data.
REQ-010 Port: req1_valid / req1_ready / req1_reg / req1_data  same widths and directions as REQ-006..009, requester 1 (load unit).
REQ-011 Port: wr_en  output  1  register-file write enable.
REQ-012 Port: wr_reg  output  ADDR_WIDTH  register-file write index.
REQ-013 Port: wr_data  output  DATA_WIDTH  register-file write data.
REQ-014 Port: idle  output  1  both queues empty and wr_en low.

Function
REQ-015 Transfer on reqN occurs at a posedge where reqN_valid and reqN_ready are both 1; the {reg, data} pair is pushed into queue N.
REQ-016 reqN_ready = 1 when queue N holds fewer than FIFO_DEPTH entries; a queue pop in the same cycle does not raise ready (no combinational pop-to-ready path).
REQ-017 Each queue: read/write pointers wrap modulo FIFO_DEPTH; occupancy counter 0..FIFO_DEPTH; never overflows or underflows.
REQ-018 Each cycle at most one queue head is granted; the grant pops that head and registers it onto wr_reg/wr_data with wr_en=1 at the next posedge.
REQ-019 Round-robin: when both heads are present, grant the queue not granted last; when one head is present, grant it; last-grant pointer updates only on a grant.
REQ-020 No grant in a cycle -> wr_en=0 at the next posedge; wr_reg/wr_data hold previous values.
REQ-021 Latency: an entry pushed at edge k into an empty, uncontended queue appears on wr_* after edge k+1; the register file commits it at edge k+2.
REQ-022 Ordering: writes from one requester reach wr_* in acceptance order.
REQ-023 Push and pop on the same queue in the same cycle are both honoured; occupancy is unchanged.
REQ-024 Same-register writes from both requesters are not merged; the later grant wins in the register file.
REQ-025 idle is combinational from queue counters and wr_en.

Reset
REQ-026 rst asserted asynchronously clears: both queues empty, wr_en=0, wr_reg=0, wr_data=0, last-grant pointer = requester 1 (so requester 0 wins the first tie).
REQ-027 rst mid-operation discards all queued writes; no partial write is issued after release.
REQ-028 During reset: req0_ready=0, req1_ready=0, idle=1; the first acceptance is possible at the first posedge after deassertion.

Configuration
REQ-029 Macro WR_ARB_X0_FILTER_EN defined: a transfer with reqN_reg=0 is accepted (handshake completes) but not enqueued and never produces wr_en.
REQ-030 Macro WR_ARB_X0_FILTER_EN undefined: x0 writes are queued and issued like any other write; the register file ignores them.

Verification
REQ-031 Single write: req0 reg=5 data=0xDEADBEEF at edge 1 -> wr_en=1, wr_reg=5, wr_data=0xDEADBEEF after edge 2; a read of x5 returns 0xDEADBEEF after edge 3.
REQ-032 Contention: both valid every cycle, req0 regs 1,2 and req1 regs 3,4 -> wr_reg sequence 1,3,2,4 with no idle cycles.
REQ-033 Backpressure: three back-to-back req1 offers with FIFO_DEPTH=2 and req0 contending -> req1_ready drops to 0 on the third offer; all three writes are eventually issued in order, none are lost.
REQ-034 x0: req0 reg=0 data=0xFFFFFFFF -> with WR_ARB_X0_FILTER_EN no wr_en pulse; without it wr_en=1 with wr_reg=0; in both cases a read of x0 returns 0.
REQ-035 Reset mid-stream: two entries queued per requester, rst pulsed -> wr_en=0 immediately, idle=1, no queued write is issued after release.
REQ-036 Random run of 1000 transactions scored against a reference register-file model; rd_data always matches and the count of issued writes equals the count of accepted non-filtered writes.
